// File: rtl/node_activity_monitor.sv
// Window-based activity monitor for one internal netlist node: counts logic-1 cycles and
// toggles, then flags rare activation. Optional macro NODE_ACT_STUCK_DETECT_EN adds a zero-toggle verdict.
module node_activity_monitor #(
  parameter int WINDOW   = 1024,
  parameter int CNT_W    = 11,
  parameter int RARE_THR = 8
) (
  input  logic             I1470_clk,
  input  logic             I1477_rst,
  input  logic             start,
  input  logic             node_in,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] ones_cnt,
  output logic [CNT_W-1:0] tog_cnt,
  output logic             rare_flag,
  output logic             stuck_flag
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] LO_THR   = CNT_W'(RARE_THR);
  localparam logic [CNT_W-1:0] HI_THR   = CNT_W'(WINDOW - RARE_THR);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] win_r;
  logic [CNT_W-1:0] ones_r;
  logic [CNT_W-1:0] tog_r;
  logic             prev_r;
  logic             first_r;
  logic             busy_r;
  logic             valid_r;
  logic             rare_r;
  logic [CNT_W-1:0] ones_nxt_s;
  logic [CNT_W-1:0] tog_nxt_s;
  logic             toggle_s;
  logic             rare_nxt_s;
`ifdef NODE_ACT_STUCK_DETECT_EN
  logic             stuck_r;
  logic             stuck_nxt_s;
`endif

  // Next counter values for the current sample, saturating, plus the verdicts they imply
  always_comb begin
    toggle_s   = 1'b0;
    ones_nxt_s = ones_r;
    tog_nxt_s  = tog_r;
    rare_nxt_s = 1'b0;
    // The first sample has no predecessor, so it can never be a toggle
    if (!first_r && (node_in != prev_r)) begin
      toggle_s = 1'b1;
    end else begin
      toggle_s = 1'b0;
    end
    if (node_in && (ones_r != CNT_MAX)) begin
      ones_nxt_s = ones_r + CNT_ONE;
    end else begin
      ones_nxt_s = ones_r;
    end
    if (toggle_s && (tog_r != CNT_MAX)) begin
      tog_nxt_s = tog_r + CNT_ONE;
    end else begin
      tog_nxt_s = tog_r;
    end
`ifdef NODE_ACT_STUCK_DETECT_EN
    stuck_nxt_s = (tog_nxt_s == CNT_ZERO);
    rare_nxt_s  = (ones_nxt_s < LO_THR) || (ones_nxt_s > HI_THR) || stuck_nxt_s;
`else
    rare_nxt_s  = (ones_nxt_s < LO_THR) || (ones_nxt_s > HI_THR);
`endif
  end

  // Measurement FSM with counters and registered result outputs
  always_ff @(posedge I1470_clk) begin
    if (I1477_rst) begin
      state_r <= IDLE;
      win_r   <= CNT_ZERO;
      ones_r  <= CNT_ZERO;
      tog_r   <= CNT_ZERO;
      prev_r  <= 1'b0;
      first_r <= 1'b0;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      rare_r  <= 1'b0;
`ifdef NODE_ACT_STUCK_DETECT_EN
      stuck_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= SAMPLE;
            win_r   <= CNT_ZERO;
            ones_r  <= CNT_ZERO;
            tog_r   <= CNT_ZERO;
            prev_r  <= 1'b0;
            first_r <= 1'b1;
            busy_r  <= 1'b1;
            rare_r  <= 1'b0;
`ifdef NODE_ACT_STUCK_DETECT_EN
            stuck_r <= 1'b0;
`endif
          end
        end
        SAMPLE: begin
          ones_r  <= ones_nxt_s;
          tog_r   <= tog_nxt_s;
          prev_r  <= node_in;
          first_r <= 1'b0;
          if (win_r == LAST_IDX) begin
            state_r <= HOLD;
            win_r   <= CNT_ZERO;
            valid_r <= 1'b1;
            rare_r  <= rare_nxt_s;
`ifdef NODE_ACT_STUCK_DETECT_EN
            stuck_r <= stuck_nxt_s;
`endif
          end else begin
            win_r <= win_r + CNT_ONE;
          end
        end
        HOLD: begin
          // Results stay frozen until the collector takes them; start is ignored here
          if (res_ready) begin
            state_r <= IDLE;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign res_valid = valid_r;
  assign ones_cnt  = ones_r;
  assign tog_cnt   = tog_r;
  assign rare_flag = rare_r;
`ifdef NODE_ACT_STUCK_DETECT_EN
  assign stuck_flag = stuck_r;
`else
  assign stuck_flag = 1'b0;
`endif

endmodule

// File: tb/tb_node_activity_monitor.sv
// Directed self-checking bench for node_activity_monitor with WINDOW=16, RARE_THR=2.
module tb_node_activity_monitor;

  localparam int CNT_W = 11;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             node_in;
  logic             busy;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] ones_cnt;
  logic [CNT_W-1:0] tog_cnt;
  logic             rare_flag;
  logic             stuck_flag;

  int checks = 0;
  int errors = 0;

`ifdef NODE_ACT_STUCK_DETECT_EN
  localparam logic STUCK_EN = 1'b1;
`else
  localparam logic STUCK_EN = 1'b0;
`endif

  node_activity_monitor #(.WINDOW(16), .CNT_W(CNT_W), .RARE_THR(2)) dut (
    .I1470_clk (clk),
    .I1477_rst (rst),
    .start     (start),
    .node_in   (node_in),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .ones_cnt  (ones_cnt),
    .tog_cnt   (tog_cnt),
    .rare_flag (rare_flag),
    .stuck_flag(stuck_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a window and feed pat[0] as sample 1 .. pat[15] as sample 16
  task automatic run_window(input logic [15:0] pat);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_ones_clr", {21'd0, ones_cnt}, 32'd0);
    check("start_tog_clr", {21'd0, tog_cnt}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      node_in = pat[i];
      if (i == 15) check("valid_not_early", {31'd0, res_valid}, 32'd0);
      tick();
    end
    node_in = 1'b0;
    check("valid_rise", {31'd0, res_valid}, 32'd1);
  endtask

  task automatic check_result(input string tag, input int ones, input int tog,
                              input logic rare, input logic stuck);
    check({tag, "_ones"}, {21'd0, ones_cnt}, 32'(ones));
    check({tag, "_tog"}, {21'd0, tog_cnt}, 32'(tog));
    check({tag, "_rare"}, {31'd0, rare_flag}, {31'd0, rare});
    check({tag, "_stuck"}, {31'd0, stuck_flag}, {31'd0, stuck});
  endtask

  task automatic accept();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("accept_valid_drop", {31'd0, res_valid}, 32'd0);
    check("accept_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    node_in   = 1'b0;
    res_ready = 1'b0;
    tick();
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, res_valid}, 32'd0);
    check("rst_ones", {21'd0, ones_cnt}, 32'd0);
    check("rst_tog", {21'd0, tog_cnt}, 32'd0);
    check("rst_rare", {31'd0, rare_flag}, 32'd0);
    check("rst_stuck", {31'd0, stuck_flag}, 32'd0);
    rst = 1'b0;
    tick();

    // Reset in the middle of a window
    start = 1'b1;
    tick();
    start   = 1'b0;
    node_in = 1'b1;
    repeat (5) tick();
    check("mid_ones", {21'd0, ones_cnt}, 32'd5);
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    node_in = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_ones", {21'd0, ones_cnt}, 32'd0);
    check("midrst_valid", {31'd0, res_valid}, 32'd0);
    tick();
    check("midrst_stay_idle", {31'd0, busy}, 32'd0);

    // Full window of ones after the reset: 16 > 14, no toggles
    run_window(16'hFFFF);
    check_result("ones16", 16, 0, 1'b1, STUCK_EN);
    accept();

    // Constant zero
    run_window(16'h0000);
    check_result("zero", 0, 0, 1'b1, STUCK_EN);
    accept();

    // Alternating 1,0,1,0...
    run_window(16'h5555);
    check_result("alt", 8, 15, 1'b0, 1'b0);
    accept();

    // Single 1 on the first sample
    run_window(16'h0001);
    check_result("first1", 1, 1, 1'b1, 1'b0);
    accept();

    // Single 0 on the last sample
    run_window(16'h7FFF);
    check_result("last0", 15, 1, 1'b1, 1'b0);
    accept();

    // Backpressure with start pulses ignored in HOLD
    run_window(16'h00FF);
    for (int c = 0; c < 10; c++) begin
      start = (c == 2 || c == 5) ? 1'b1 : 1'b0;
      tick();
      check("bp_valid", {31'd0, res_valid}, 32'd1);
      check("bp_busy", {31'd0, busy}, 32'd1);
      check("bp_ones", {21'd0, ones_cnt}, 32'd8);
      check("bp_tog", {21'd0, tog_cnt}, 32'd1);
      check("bp_rare", {31'd0, rare_flag}, 32'd0);
    end
    start = 1'b0;
    accept();
    repeat (3) tick();
    check("bp_no_restart", {31'd0, busy}, 32'd0);
    check("bp_hold_ones", {21'd0, ones_cnt}, 32'd8);
    check("bp_hold_valid", {31'd0, res_valid}, 32'd0);

    // Back-to-back: second window starts the cycle after acceptance
    run_window(16'hFFFF);
    check_result("b2b_a", 16, 0, 1'b1, STUCK_EN);
    accept();
    run_window(16'h0003);
    check_result("b2b_b", 2, 1, 1'b0, 1'b0);
    accept();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
